// File: rtl/ntt_intt_ip_pkg.sv
// Shared types and constants for the Kyber NTT/INTT butterfly scheduler.
package ntt_intt_ip_pkg;

  localparam int N_COEFF    = 256;
  localparam int NUM_LAYERS = 7;
  localparam int KYBER_Q    = 3329;

  typedef enum logic [1:0] {
    BF_CT    = 2'b00,
    BF_GS    = 2'b01,
    BF_SCALE = 2'b10
  } bf_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SCALE  = 3'd3,
    ST_SDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ntt_intt_bf_idx_gen.sv
// Combinational map (mode, layer, butterfly count, scale) -> coefficient pair, twiddle index, op.
// Zero latency; no flow control of its own.
module ntt_intt_bf_idx_gen
  import ntt_intt_ip_pkg::*;
(
  input  logic       mode_i,
  input  logic [2:0] layer_i,
  input  logic [6:0] b_i,
  input  logic       scale_i,
  output logic [7:0] idx_a_o,
  output logic [7:0] idx_b_o,
  output logic [6:0] zeta_idx_o,
  output bf_op_e     op_o
);

  logic [3:0] s;
  logic [7:0] len;
  logic [6:0] len_m1;
  logic [6:0] g;
  logic [6:0] off;
  logic [7:0] idx_a;

  always_comb begin
    // NTT halves the butterfly span each layer, INTT doubles it
    s      = mode_i ? ({1'b0, layer_i} + 4'd1) : (4'd7 - {1'b0, layer_i});
    len    = 8'd1 << s;
    len_m1 = 7'(len - 8'd1);
    g      = b_i >> s;
    off    = b_i & len_m1;
    idx_a  = ({1'b0, g} << (s + 4'd1)) | {1'b0, off};

    idx_a_o    = idx_a;
    idx_b_o    = idx_a + len;
    zeta_idx_o = mode_i ? ((7'd127 >> layer_i) - g) : ((7'd1 << layer_i) + g);
    op_o       = mode_i ? BF_GS : BF_CT;

    if (scale_i) begin
      idx_a_o    = {b_i, 1'b0};
      idx_b_o    = {b_i, 1'b1};
      zeta_idx_o = '0;
      op_o       = BF_SCALE;
    end
  end

endmodule

// File: rtl/ntt_intt_bf_sched.sv
// Butterfly-issue scheduler: walks 7 layers (plus INTT scale pass), one tuple per valid/ready fire.
// Tuples are combinational from registered state; issue stalls at MAX_OUT in flight and drains between layers.
module ntt_intt_bf_sched
  import ntt_intt_ip_pkg::*;
#(
  parameter int MAX_OUT = 8,
  parameter int OUT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] layer_o,
  output logic       bf_valid_o,
  input  logic       bf_ready_i,
  output logic [7:0] bf_idx_a_o,
  output logic [7:0] bf_idx_b_o,
  output logic [6:0] bf_zeta_idx_o,
  output logic [1:0] bf_op_o,
  input  logic       bf_wb_i,
  output logic       err_o
);

  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] ONE_C     = OUT_W'(1);
  localparam logic [6:0]       LAST_B    = 7'(N_COEFF / 2 - 1);
  localparam logic [2:0]       LAST_L    = 3'(NUM_LAYERS - 1);

  sched_state_e     state_q, state_d;
  logic             mode_q, mode_d;
  logic [2:0]       l_q, l_d;
  logic [6:0]       b_q, b_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic             issuing;
  logic             vld;
  logic             fire;
  logic [7:0]       gen_a;
  logic [7:0]       gen_b;
  logic [6:0]       gen_z;
  bf_op_e           gen_op;

  ntt_intt_bf_idx_gen u_idx_gen (
    .mode_i     (mode_q),
    .layer_i    (l_q),
    .b_i        (b_q),
    .scale_i    (state_q == ST_SCALE),
    .idx_a_o    (gen_a),
    .idx_b_o    (gen_b),
    .zeta_idx_o (gen_z),
    .op_o       (gen_op)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      l_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      l_q     <= l_d;
      b_q     <= b_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    issuing = (state_q == ST_ISSUE) || (state_q == ST_SCALE);
    vld     = issuing && (out_q < MAX_OUT_C);
    fire    = vld && bf_ready_i;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    l_d     = l_q;
    b_d     = b_q;
    out_d   = out_q;
    // A write-back with nothing in flight is flagged and otherwise ignored
    err_d   = bf_wb_i && (out_q == '0);

    if (fire) begin
      out_d = out_d + ONE_C;
    end
    if (bf_wb_i && (out_q != '0)) begin
      out_d = out_d - ONE_C;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          l_d     = '0;
          b_d     = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_SCALE: begin
        if (fire) begin
          b_d = b_q + 7'd1;
          if (b_q == LAST_B) begin
            state_d = (state_q == ST_ISSUE) ? ST_DRAIN : ST_SDRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_q == '0) begin
          b_d = '0;
          if (l_q != LAST_L) begin
            l_d     = l_q + 3'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = mode_q ? ST_SCALE : ST_DONE;
          end
        end
      end
      ST_SDRAIN: begin
        if (out_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        l_d     = '0;
        b_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d = ST_IDLE;
      l_d     = '0;
      b_d     = '0;
      out_d   = '0;
    end
  end

  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    done_o        = (state_q == ST_DONE);
    layer_o       = ((state_q == ST_SCALE) || (state_q == ST_SDRAIN)) ? 3'd7 : l_q;
    bf_valid_o    = vld;
    bf_idx_a_o    = '0;
    bf_idx_b_o    = '0;
    bf_zeta_idx_o = '0;
    bf_op_o       = 2'b00;
    if (issuing) begin
      bf_idx_a_o    = gen_a;
      bf_idx_b_o    = gen_b;
      bf_zeta_idx_o = gen_z;
      bf_op_o       = gen_op;
    end
    err_o = err_q;
  end

endmodule

// File: tb/tb_ntt_intt_bf_sched.sv
// Scoreboard bench for the NTT/INTT butterfly scheduler against a loop-nest reference model.
module tb_ntt_intt_bf_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       bf_ready_i = 1'b0;
  logic       bf_wb_i = 1'b0;
  logic       busy_o, done_o, bf_valid_o, err_o;
  logic [2:0] layer_o;
  logic [7:0] bf_idx_a_o, bf_idx_b_o;
  logic [6:0] bf_zeta_idx_o;
  logic [1:0] bf_op_o;

  ntt_intt_bf_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .layer_o(layer_o),
    .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i),
    .bf_idx_a_o(bf_idx_a_o), .bf_idx_b_o(bf_idx_b_o), .bf_zeta_idx_o(bf_zeta_idx_o),
    .bf_op_o(bf_op_o), .bf_wb_i(bf_wb_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] z;
    logic [1:0] op;
    logic [2:0] lay;
  } tup_t;

  tup_t exp_q[$];
  int   wbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lat = 3;
  int   rdy_mode = 0;
  int   stall_lo = 0;
  int   stall_hi = -1;
  logic spur_wb = 1'b0;

  int   t0 = 0;
  int   run_fires = 0;
  int   model_out = 0;
  int   max_out = 0;
  int   done_cnt = 0;
  int   done_rel = -1;
  int   last_fire = -1;
  int   first_fire[8];
  bit   active = 1'b0;
  bit   prev_spur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_tup(input string name, input tup_t act, input tup_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got a=%0d b=%0d z=%0d op=%0d layer=%0d expected a=%0d b=%0d z=%0d op=%0d layer=%0d (cycle %0d)",
               name, act.a, act.b, act.z, act.op, act.lay, e.a, e.b, e.z, e.op, e.lay, cyc);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  function automatic tup_t mk(input int a, input int b, input int z, input int op, input int lay);
    tup_t t;
    t.a = 8'(a); t.b = 8'(b); t.z = 7'(z); t.op = 2'(op); t.lay = 3'(lay);
    return t;
  endfunction

  // Kyber reference loop nests: NTT zetas count up from 1, INTT zetas count down from 127
  task automatic build(input bit m);
    int k;
    int len;
    k = m ? 127 : 1;
    for (int lay = 0; lay < 7; lay++) begin
      len = m ? (2 << lay) : (128 >> lay);
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) exp_q.push_back(mk(j, j + len, k, m ? 1 : 0, lay));
        k = m ? k - 1 : k + 1;
      end
    end
    if (m) for (int i = 0; i < 128; i++) exp_q.push_back(mk(2 * i, 2 * i + 1, 0, 2, 7));
  endtask

  // Input drivers for ready and write-back, offset from the main stimulus to avoid races
  always @(posedge clk) begin
    #2;
    bf_wb_i = spur_wb || (wbq.size() > 0 && wbq[0] == cyc);
    if (wbq.size() > 0 && wbq[0] == cyc) void'(wbq.pop_front());
    case (rdy_mode)
      0:       bf_ready_i = 1'b1;
      1:       bf_ready_i = ($urandom_range(0, 3) != 0);
      default: bf_ready_i = !(active && (cyc - t0) >= stall_lo && (cyc - t0) <= stall_hi);
    endcase
  end

  // Monitor: model the outstanding count and busy window, pop and compare the tuple stream
  always @(negedge clk) begin
    tup_t cur;
    bit   fire_c;
    bit   was_active;
    bit   spur;
    cur = {bf_idx_a_o, bf_idx_b_o, bf_zeta_idx_o, bf_op_o, layer_o};
    if (!rst_n) begin
      active = 1'b0; model_out = 0; prev_spur = 1'b0;
      exp_q.delete();
    end else begin
      fire_c     = bf_valid_o && bf_ready_i;
      was_active = active;
      chk("busy", busy_o, was_active);
      chk("err", err_o, prev_spur);
      if (!was_active) chk("idle_valid", bf_valid_o, 0);
      else if ((run_fires % 128) != 0) chk("valid_rule", bf_valid_o, model_out < 8);
      else if (model_out >= 8) chk("valid_cap", bf_valid_o, 0);

      if (was_active && bf_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_tuple: got a=%0d b=%0d expected no tuple (cycle %0d)", cur.a, cur.b, cyc);
        end else begin
          chk_tup("tuple", cur, exp_q[0]);
          if (fire_c) begin
            void'(exp_q.pop_front());
            if ((run_fires % 128) == 0) first_fire[run_fires / 128] = cyc - t0;
            last_fire = cyc - t0;
            run_fires++;
            wbq.push_back(cyc + lat);
          end
        end
      end

      if (done_o) begin
        done_cnt++;
        done_rel = cyc - t0;
        chk("done_all_issued", exp_q.size(), 0);
        active = 1'b0;
      end

      spur = bf_wb_i && (model_out == 0);
      if (bf_wb_i && model_out > 0) model_out--;
      if (fire_c) model_out++;
      if (model_out > max_out) max_out = model_out;
      prev_spur = spur;

      if (abort_i) begin
        active = 1'b0; model_out = 0;
        exp_q.delete();
      end else if (start_i && !was_active) begin
        active = 1'b1; t0 = cyc; run_fires = 0; done_rel = -1; last_fire = -1;
        foreach (first_fire[i]) first_fire[i] = -1;
        build(mode_i);
      end
    end
  end

  task automatic start_run(input bit m);
    @(posedge clk); #1 mode_i = m; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (active && n < 6000) begin @(posedge clk); n++; end
    if (n >= 6000) fail_note(name);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (wbq.size() > 0 && n < 200) begin @(posedge clk); n++; end
    if (n >= 200) fail_note("wb_drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int target, input string name);
    int n;
    n = 0;
    while (run_fires < target && n < 6000) begin @(posedge clk); n++; end
    if (n >= 6000) fail_note(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_layer"}, layer_o, 0);
    chk({name, "_valid"}, bf_valid_o, 0);
    chk({name, "_idx_a"}, bf_idx_a_o, 0);
    chk({name, "_idx_b"}, bf_idx_b_o, 0);
    chk({name, "_zeta"}, bf_zeta_idx_o, 0);
    chk({name, "_op"}, bf_op_o, 0);
    chk({name, "_err"}, err_o, 0);
  endtask

  initial begin
    int d0;
    bit m;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Spurious write-back while idle
    #1 spur_wb = 1'b1;
    @(posedge clk); #1 spur_wb = 1'b0;
    @(negedge clk);
    chk("idle_spur_err", err_o, 1);
    wait_quiet();

    // NTT, ready always high, latency 3, with an ignored start mid-run
    lat = 3; rdy_mode = 0;
    start_run(1'b0);
    repeat (400) @(posedge clk);
    #1 start_i = 1'b1; mode_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done("ntt_done");
    @(negedge clk);
    chk("ntt_busy_after_done", busy_o, 0);
    chk("ntt_first_l0", first_fire[0], 1);
    chk("ntt_last_l0", first_fire[0] + 127, 128);
    chk("ntt_first_l1", first_fire[1], 133);
    chk("ntt_done_cycle", done_rel, 925);
    chk("ntt_fires", run_fires, 896);
    chk("ntt_done_count", done_cnt, 1);
    wait_quiet();

    // INTT with scale pass
    start_run(1'b1);
    wait_done("intt_done");
    chk("intt_first_l0", first_fire[0], 1);
    chk("intt_scale_first", first_fire[7], 925);
    chk("intt_scale_last", last_fire, 1052);
    chk("intt_done_cycle", done_rel, 1057);
    chk("intt_fires", run_fires, 1024);
    wait_quiet();

    // Five-cycle backpressure inside layer 2
    rdy_mode = 2; stall_lo = 300; stall_hi = 304;
    start_run(1'b0);
    wait_done("stall_done");
    chk("stall_first_l2", first_fire[2], 265);
    chk("stall_done_cycle", done_rel, 930);
    chk("stall_fires", run_fires, 896);
    wait_quiet();

    // Long write-back latency saturates the in-flight limit
    lat = 20; rdy_mode = 0; max_out = 0;
    start_run(1'b0);
    wait_done("maxout_done");
    chk("maxout_peak", max_out, 8);
    chk("maxout_fires", run_fires, 896);
    wait_quiet();

    // Randomised mode, latency and ready
    for (int r = 0; r < 2; r++) begin
      m = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 7); rdy_mode = 1;
      d0 = done_cnt;
      start_run(m);
      wait_done("rand_done");
      chk("rand_fires", run_fires, m ? 1024 : 896);
      chk("rand_done_count", done_cnt, d0 + 1);
      wait_quiet();
    end

    // Abort in layer 3, then a clean restart
    lat = 4; rdy_mode = 1;
    start_run(1'b0);
    wait_fires(3 * 128 + 40, "abort_reach");
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    d0 = done_cnt;
    repeat (30) @(posedge clk);
    chk("abort_no_done", done_cnt, d0);
    wait_quiet();
    lat = 2; rdy_mode = 0;
    start_run(1'b0);
    wait_done("restart_done");
    chk("restart_fires", run_fires, 896);
    chk("restart_done_cycle", done_rel, 918);
    wait_quiet();

    // Reset mid-run
    lat = 3; rdy_mode = 0;
    start_run(1'b1);
    wait_fires(300, "reset_reach");
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrun_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    wait_quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
